turret_motion_sequencer: RTL
============================

// Module: turret_motion_sequencer
// PURPOSE
//  Fabric-side controller for the turret actuators behind the MSS APB slave. It slews the
//  pan and tilt servo pulse widths toward targets written over APB, one rate-limited step per
//  20 ms servo frame, and drives pwm_out1 and pwm_out2. It sequences IR shots as a carrier
//  burst followed by a cooldown. It also debounces hit_data into a sticky FABINT interrupt.
// PARAMETERS
//  W            21         width of frame counter / pulse-width values
//  PERIOD       2000000    servo frame length in PCLK cycles (20 ms @ 100 MHz)
//  MIN_PW       100000     minimum legal pulse width, cycles (1.0 ms)
//  MAX_PW       200000     maximum legal pulse width, cycles (2.0 ms)
//  STEP         1000       max pulse-width change per frame per axis, cycles
//  IR_DIV       1316       IR carrier half-period, cycles (~38 kHz)
//  FIRE_CYCLES  5000000    IR burst length, cycles
//  COOL_CYCLES  100000000  post-shot lockout, cycles
// PORTS
//  PCLK       in   1  fabric clock (FAB_CLK)
//  PRESET     in   1  synchronous active-high reset
//  tgt_pan    in   W  pan target pulse width
//  tgt_tilt   in   W  tilt target pulse width
//  tgt_valid  in   1  1-cycle strobe: capture tgt_pan/tgt_tilt
//  fire_req   in   1  1-cycle strobe: request a shot
//  hit_data   in   1  async IR-receiver output, active low
//  int_clr    in   1  1-cycle strobe: clear hit interrupt
//  pwm_out1   out  1  pan servo PWM
//  pwm_out2   out  1  tilt servo PWM
//  pwm_out_IR out  1  IR LED drive (carrier during burst)
//  busy       out  1  fire FSM not IDLE
//  at_target  out  1  both current widths equal their targets
//  FABINT     out  1  sticky hit interrupt
//  hit_cnt    out  8  saturating hit counter
// BEHAVIOUR
//  - Clock and reset: single clock PCLK. PRESET is synchronous and active-high; all state
//    is updated on the rising edge of PCLK.
//  - Values after reset: frame ctr=0; cur and tgt for both axes = CENTER=(MIN_PW+MAX_PW)/2;
//    FSM=IDLE; pwm_out_IR=0; FABINT=0; hit_cnt=0; busy=0; at_target=1; sync flops=1.
//  - Reset asserted mid-operation: aborts any burst or slew; outputs follow the reset values
//    on the next edge.
//  - Frame counter: counts 0..PERIOD-1, then wraps to 0. frame_tick is asserted when the
//    count equals PERIOD-1.
//  - Servo PWM: pwm_outN = (ctr < curN), registered, so it lags ctr by 1 cycle. curN changes
//    only on frame_tick, so every frame carries one constant pulse width.
//  - Target capture: when tgt_valid is high, each target is clamped to [MIN_PW,MAX_PW] and
//    registered on that edge.
//  - Slew step: on frame_tick, curN += sign(tgtN-curN)*min(STEP,|tgtN-curN|). Compute the
//    difference signed at W+1 bits; curN never overshoots tgtN.
//  - tgt_valid and frame_tick in the same cycle: that tick steps toward the OLD target; the
//    new target applies from the next tick.
//  - at_target: combinational, (cur_pan==tgt_pan)&&(cur_tilt==tgt_tilt).
//  - Fire FSM states: IDLE, FIRE, COOL.
//      IDLE: fire_req -> FIRE; load timer=FIRE_CYCLES-1 and carrier divider=0;
//            pwm_out_IR=1 on the first FIRE cycle.
//      FIRE: pwm_out_IR toggles every IR_DIV cycles. When timer==0 -> COOL; load
//            timer=COOL_CYCLES-1; pwm_out_IR=0.
//      COOL: pwm_out_IR=0. When timer==0 -> IDLE.
//      fire_req arriving in FIRE or COOL is dropped, not queued.
//  - busy: asserted while the FSM is in FIRE or COOL.
//  - Hit detect: hit_data passes through a 2-flop synchronizer. A falling edge of the
//    synchronized signal (1->0) sets FABINT and increments hit_cnt, saturating at 255.
//  - Hit latency: FABINT rises 3 PCLK edges after the first edge that samples hit_data=0.
//  - Hit clear: int_clr clears FABINT. If int_clr and a new hit edge occur in the same cycle,
//    set wins and hit_cnt still increments.
// TESTING  (bench params: PERIOD=100 MIN_PW=10 MAX_PW=20 STEP=3 IR_DIV=2
//           FIRE_CYCLES=20 COOL_CYCLES=30)
//  1. Reset -> pwm_out1/2 high for 15 of every 100 cycles; IR=0; FABINT=0; busy=0;
//     at_target=1.
//  2. tgt_valid with pan=20, tilt=5 (tilt clamps to 10) -> pan widths per frame 15,18,20,20;
//     tilt widths 15,12,10,10; at_target rises at the 2nd tick.
//  3. fire_req -> IR pattern 1,1,0,0,... for 20 cycles, then 0; busy=1 for 50 cycles;
//     fire_req at cycle 30 ignored; fire_req after busy falls starts a new burst.
//  4. hit_data 1->0 -> FABINT=1 after 3 edges, hit_cnt=1; int_clr -> FABINT=0;
//     int_clr coinciding with the next hit edge -> FABINT=1, hit_cnt=2;
//     256 hits -> hit_cnt=255.
//  5. tgt_valid (pan=10) in the frame_tick cycle while slewing to 20 from 15 -> that tick
//     gives 18, later ticks give 15,12,10.
//  6. PRESET mid-burst with pan at 20 -> next edge: IR=0, busy=0, pan width 15,
//     FABINT=0, hit_cnt=0.

Source files
------------

// File: rtl/turret_motion_sequencer.sv
// Turret actuator controller: rate-limited pan/tilt servo PWM, IR shot sequencer
// (carrier burst then cooldown) and a debounced, sticky hit interrupt.
module turret_motion_sequencer #(
    parameter int W           = 21,
    parameter int PERIOD      = 2000000,
    parameter int MIN_PW      = 100000,
    parameter int MAX_PW      = 200000,
    parameter int STEP        = 1000,
    parameter int IR_DIV      = 1316,
    parameter int FIRE_CYCLES = 5000000,
    parameter int COOL_CYCLES = 100000000
) (
    input  logic         PCLK,
    input  logic         PRESET,
    input  logic [W-1:0] tgt_pan,
    input  logic [W-1:0] tgt_tilt,
    input  logic         tgt_valid,
    input  logic         fire_req,
    input  logic         hit_data,
    input  logic         int_clr,
    output logic         pwm_out1,
    output logic         pwm_out2,
    output logic         pwm_out_IR,
    output logic         busy,
    output logic         at_target,
    output logic         FABINT,
    output logic [7:0]   hit_cnt
);

    localparam logic [W-1:0]        CENTER    = W'((MIN_PW + MAX_PW) / 2);
    localparam logic [W-1:0]        MIN_V     = W'(MIN_PW);
    localparam logic [W-1:0]        MAX_V     = W'(MAX_PW);
    localparam logic [W-1:0]        STEP_V    = W'(STEP);
    localparam logic signed [W:0]   STEP_S    = (W+1)'(STEP);
    localparam logic [W-1:0]        LAST      = W'(PERIOD - 1);
    localparam logic [31:0]         FIRE_LOAD = 32'(FIRE_CYCLES - 1);
    localparam logic [31:0]         COOL_LOAD = 32'(COOL_CYCLES - 1);
    localparam logic [15:0]         DIV_LAST  = 16'(IR_DIV - 1);

    // Handshake: tgt_valid, fire_req and int_clr are single-cycle strobes with no
    // ready; each is acted on at the edge that samples it high, and fire_req is
    // dropped (never queued) while busy is high.

    typedef enum logic [1:0] {IDLE, FIRE, COOL} fire_state_t;

    logic [W-1:0] ctr;
    logic         frame_tick;
    logic [W-1:0] cur_pan, cur_tilt, tgt_pan_q, tgt_tilt_q;

    fire_state_t  state, state_next;
    logic [31:0]  timer, timer_next;
    logic [15:0]  div, div_next;
    logic         ir, ir_next;

    logic         sync1, sync2, hit_prev, hit_edge;

    function automatic logic [W-1:0] clamp_pw(input logic [W-1:0] v);
        if (v < MIN_V) return MIN_V;
        if (v > MAX_V) return MAX_V;
        return v;
    endfunction

    // Signed W+1 difference so widths near the top of the range cannot wrap.
    function automatic logic [W-1:0] slew(input logic [W-1:0] cur, input logic [W-1:0] tgt);
        logic signed [W:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > STEP_S) return cur + STEP_V;
        if (diff < -STEP_S) return cur - STEP_V;
        return tgt;
    endfunction

    assign frame_tick = (ctr == LAST);
    assign at_target  = (cur_pan == tgt_pan_q) && (cur_tilt == tgt_tilt_q);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctr        <= '0;
            cur_pan    <= CENTER;
            cur_tilt   <= CENTER;
            tgt_pan_q  <= CENTER;
            tgt_tilt_q <= CENTER;
            pwm_out1   <= 1'b0;
            pwm_out2   <= 1'b0;
        end else begin
            ctr <= frame_tick ? '0 : ctr + 1'b1;
            if (tgt_valid) begin
                tgt_pan_q  <= clamp_pw(tgt_pan);
                tgt_tilt_q <= clamp_pw(tgt_tilt);
            end
            // A target written on the tick edge only takes effect from the next tick.
            if (frame_tick) begin
                cur_pan  <= slew(cur_pan, tgt_pan_q);
                cur_tilt <= slew(cur_tilt, tgt_tilt_q);
            end
            pwm_out1 <= (ctr < cur_pan);
            pwm_out2 <= (ctr < cur_tilt);
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
            timer <= '0;
            div   <= '0;
            ir    <= 1'b0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            div   <= div_next;
            ir    <= ir_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer;
        div_next   = div;
        ir_next    = ir;
        case (state)
            IDLE: begin
                ir_next = 1'b0;
                if (fire_req) begin
                    state_next = FIRE;
                    timer_next = FIRE_LOAD;
                    div_next   = '0;
                    ir_next    = 1'b1;
                end
            end
            FIRE: begin
                if (timer == '0) begin
                    state_next = COOL;
                    timer_next = COOL_LOAD;
                    ir_next    = 1'b0;
                end else begin
                    timer_next = timer - 1'b1;
                    if (div == DIV_LAST) begin
                        div_next = '0;
                        ir_next  = ~ir;
                    end else begin
                        div_next = div + 1'b1;
                    end
                end
            end
            COOL: begin
                ir_next = 1'b0;
                if (timer == '0) state_next = IDLE;
                else timer_next = timer - 1'b1;
            end
            default: begin
                state_next = IDLE;
                ir_next    = 1'b0;
            end
        endcase
    end

    assign pwm_out_IR = ir;
    assign busy       = (state != IDLE);

    // hit_data is active low and idles high, so the sync chain resets to 1.
    assign hit_edge = hit_prev & ~sync2;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            hit_prev <= 1'b1;
            FABINT   <= 1'b0;
            hit_cnt  <= '0;
        end else begin
            sync1    <= hit_data;
            sync2    <= sync1;
            hit_prev <= sync2;
            if (hit_edge) begin
                FABINT <= 1'b1;
                if (hit_cnt != 8'hFF) hit_cnt <= hit_cnt + 8'd1;
            end else if (int_clr) begin
                FABINT <= 1'b0;
            end
        end
    end

endmodule
